// File: rtl/lm_sm_sequencer.sv
// Register-list walker for LM/SM: emits one (register, address) pair per
// transfer, lowest register first, and pulses done when the mask empties.
module lm_sm_sequencer #(
    parameter int ADDR_W = 16,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              start,
    input  logic [7:0]        reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              step,
    output logic              busy,
    output logic              valid,
    output logic [2:0]        reg_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        count,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mask;
    logic [7:0]        w_mask_nxt;
    logic [7:0]        w_mask_clr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [3:0]        r_count;
    logic [3:0]        w_count_nxt;
    logic [2:0]        w_reg_addr;

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_mem_addr <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mask     <= w_mask_nxt;
            r_mem_addr <= w_addr_nxt;
            r_count    <= w_count_nxt;
        end
    end

    // Lowest set bit wins; an empty mask yields index 0.
    always_comb begin
        w_reg_addr = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i]) w_reg_addr = 3'(i);
        end
    end

    assign w_mask_clr = r_mask & (r_mask - 8'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_addr_nxt  = r_mem_addr;
        w_count_nxt = r_count;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mask_nxt  = reg_list;
                    w_addr_nxt  = base_addr;
                    w_count_nxt = 4'd0;
                    w_state_nxt = (reg_list != 8'd0) ? S_ACTIVE : S_DONE;
                end
            end
            S_ACTIVE: begin
                if (step) begin
                    w_mask_nxt  = w_mask_clr;
                    w_addr_nxt  = r_mem_addr + ADDR_W'(STRIDE);
                    w_count_nxt = r_count + 4'd1;
                    if (w_mask_clr == 8'd0) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign valid    = (r_state == S_ACTIVE);
    assign done     = (r_state == S_DONE);
    assign reg_addr = w_reg_addr;
    assign mem_addr = r_mem_addr;
    assign count    = r_count;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Vector-table bench for lm_sm_sequencer with a queue of expected outputs
// and hand-written async-reset sequences.
module tb_lm_sm_sequencer;

    localparam int AW = 16;

    typedef struct {
        logic          st;
        logic [7:0]    rl;
        logic [AW-1:0] ba;
        logic          sp;
        logic          e_busy;
        logic          e_valid;
        logic [2:0]    e_ra;
        logic [AW-1:0] e_ma;
        logic [3:0]    e_cnt;
        logic          e_done;
    } vec_t;

    logic          clk;
    logic          proc_rst;
    logic          start;
    logic [7:0]    reg_list;
    logic [AW-1:0] base_addr;
    logic          step;
    logic          busy;
    logic          valid;
    logic [2:0]    reg_addr;
    logic [AW-1:0] mem_addr;
    logic [3:0]    count;
    logic          done;

    int   n_checks;
    int   n_fail;
    vec_t vecs[$];
    vec_t sb[$];

    lm_sm_sequencer #(
        .ADDR_W(AW),
        .STRIDE(1)
    ) dut (
        .clk      (clk),
        .proc_rst (proc_rst),
        .start    (start),
        .reg_list (reg_list),
        .base_addr(base_addr),
        .step     (step),
        .busy     (busy),
        .valid    (valid),
        .reg_addr (reg_addr),
        .mem_addr (mem_addr),
        .count    (count),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".busy"}, 32'(busy), 32'(e.e_busy));
        chk({tag, ".valid"}, 32'(valid), 32'(e.e_valid));
        chk({tag, ".reg_addr"}, 32'(reg_addr), 32'(e.e_ra));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(e.e_ma));
        chk({tag, ".count"}, 32'(count), 32'(e.e_cnt));
        chk({tag, ".done"}, 32'(done), 32'(e.e_done));
    endtask

    function automatic vec_t mk(
        input logic st, input logic [7:0] rl, input logic [AW-1:0] ba,
        input logic sp, input logic b, input logic v, input logic [2:0] ra,
        input logic [AW-1:0] ma, input logic [3:0] c, input logic d);
        vec_t r;
        r.st = st; r.rl = rl; r.ba = ba; r.sp = sp;
        r.e_busy = b; r.e_valid = v; r.e_ra = ra;
        r.e_ma = ma; r.e_cnt = c; r.e_done = d;
        return r;
    endfunction

    // Drive at negedge, push expectation, compare just after the posedge.
    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        start     = v.st;
        reg_list  = v.rl;
        base_addr = v.ba;
        step      = v.sp;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk_all(tag, e);
        end
    endtask

    initial begin
        vec_t z;
        n_checks  = 0;
        n_fail    = 0;
        start     = 1'b0;
        reg_list  = 8'h00;
        base_addr = '0;
        step      = 1'b0;

        // Full list, start+step together on the start cycle
        vecs.push_back(mk(1, 8'hFF, 16'h0100, 1, 1, 1, 0, 16'h0100, 0, 0));
        for (int k = 1; k < 8; k++)
            vecs.push_back(mk(0, 8'h00, 16'h0000, 1, 1, 1, 3'(k),
                              16'h0100 + 16'(k), 4'(k), 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 1, 1, 0, 0, 16'h0108, 8, 1));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 1, 0, 0, 0, 16'h0108, 8, 0));
        // Sparse list with stalls and a stray start while ACTIVE
        vecs.push_back(mk(1, 8'hA4, 16'h0020, 0, 1, 1, 2, 16'h0020, 0, 0));
        vecs.push_back(mk(1, 8'hFF, 16'h1234, 0, 1, 1, 2, 16'h0020, 0, 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 0, 1, 1, 2, 16'h0020, 0, 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 1, 1, 1, 5, 16'h0021, 1, 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 0, 1, 1, 5, 16'h0021, 1, 0));
        vecs.push_back(mk(1, 8'h01, 16'h9999, 0, 1, 1, 5, 16'h0021, 1, 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 1, 1, 1, 7, 16'h0022, 2, 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 0, 1, 1, 7, 16'h0022, 2, 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 0, 1, 1, 7, 16'h0022, 2, 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 1, 1, 0, 0, 16'h0023, 3, 1));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0023, 3, 0));
        // Step in IDLE is ignored
        vecs.push_back(mk(0, 8'h00, 16'h0000, 1, 0, 0, 0, 16'h0023, 3, 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 1, 0, 0, 0, 16'h0023, 3, 0));
        // Empty list
        vecs.push_back(mk(1, 8'h00, 16'h0500, 0, 1, 0, 0, 16'h0500, 0, 1));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0500, 0, 0));
        // Address wrap
        vecs.push_back(mk(1, 8'h03, 16'hFFFF, 0, 1, 1, 0, 16'hFFFF, 0, 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 1, 1, 1, 1, 16'h0000, 1, 0));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 1, 1, 0, 0, 16'h0001, 2, 1));
        vecs.push_back(mk(0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0001, 2, 0));

        z = mk(0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0);

        proc_rst = 1'b1;
        #2;
        proc_rst = 1'b0;
        #1;
        chk_all("reset", z);
        repeat (2) @(posedge clk);
        @(negedge clk);
        proc_rst = 1'b1;

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // Async reset after the second step of an 8'hF0 list
        apply("rst_a0", mk(1, 8'hF0, 16'h0040, 0, 1, 1, 4, 16'h0040, 0, 0));
        apply("rst_a1", mk(0, 8'h00, 16'h0000, 1, 1, 1, 5, 16'h0041, 1, 0));
        apply("rst_a2", mk(0, 8'h00, 16'h0000, 1, 1, 1, 6, 16'h0042, 2, 0));
        #2;
        proc_rst = 1'b0;
        #1;
        chk_all("rst_mid", z);
        @(posedge clk);
        #1;
        chk_all("rst_hold", z);
        @(negedge clk);
        proc_rst = 1'b1;
        apply("rst_b0", mk(0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0));
        apply("rst_b1", mk(1, 8'h01, 16'h0077, 0, 1, 1, 0, 16'h0077, 0, 0));
        apply("rst_b2", mk(0, 8'h00, 16'h0000, 1, 1, 0, 0, 16'h0078, 1, 1));
        apply("rst_b3", mk(0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0078, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
